fb_write_arbiter: RTL and testbench

- Owns the write port of the 640x480, 9-bit-per-pixel dual-port framebuffer.
- Shares that port between two pixel requesters (req/gnt handshake, round-robin) and a built-in full-frame clear engine.
- Converts (x,y) coordinates to linear addresses (y*H_RES + x).
- Sits between the drawing/capture logic and the framebuffer RAM write inputs; the read port is untouched.

---
 rtl/fb_write_arbiter_if.sv | 45 ++++
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Write-side bus of the framebuffer arbiter: two pixel requesters, the clear
// engine controls and the RAM write port. The arbiter uses the slave modport.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 9
);
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;

  // Requester handshake: reqN is held with x/y/pix stable until gntN. gntN is
  // a one-cycle accept; the write lands on the RAM port the following cycle.
  logic              req0;
  logic [9:0]        x0;
  logic [8:0]        y0;
  logic [DATA_W-1:0] pix0;
  logic              gnt0;
  logic              req1;
  logic [9:0]        x1;
  logic [8:0]        y1;
  logic [DATA_W-1:0] pix1;
  logic              gnt1;

  logic              oob_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport slave (
    input  clear_start, clear_color,
    input  req0, x0, y0, pix0,
    input  req1, x1, y1, pix1,
    output clear_busy, clear_done, gnt0, gnt1,
    output oob_err, ram_we, ram_addr, ram_data
  );

  modport master (
    output clear_start, clear_color,
    output req0, x0, y0, pix0,
    output req1, x1, y1, pix1,
    input  clear_busy, clear_done, gnt0, gnt1,
    input  oob_err, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin arbitration between two pixel
// requesters plus a full-frame clear engine, with (x,y) to linear addressing.
module fb_write_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_write_arbiter_if.slave   bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] H_LIM     = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] V_LIM     = ADDR_W'(V_RES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_cnt_q;
  logic [DATA_W-1:0]   clear_col_q;
  logic                rr_q;
  logic                oob_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic                clear_accept;
  logic                gnt0, gnt1;
  logic                busy, done;
  logic                inr0, inr1;
  logic [ADDR_W-1:0]   lin0, lin1;

  assign lin0 = ADDR_W'(bus.y0) * H_LIM + ADDR_W'(bus.x0);
  assign lin1 = ADDR_W'(bus.y1) * H_LIM + ADDR_W'(bus.x1);
  assign inr0 = (ADDR_W'(bus.x0) < H_LIM) && (ADDR_W'(bus.y0) < V_LIM);
  assign inr1 = (ADDR_W'(bus.x1) < H_LIM) && (ADDR_W'(bus.y1) < V_LIM);

  // rr_q=0 favours requester 0 on a tie; it flips to the other side on a grant.
  always_comb begin
    state_d      = state_q;
    clear_accept = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clear_start) begin
          clear_accept = 1'b1;
          state_d      = S_CLEAR;
        end else if (bus.req0 && bus.req1) begin
          gnt0 = ~rr_q;
          gnt1 = rr_q;
        end else begin
          gnt0 = bus.req0;
          gnt1 = bus.req1;
        end
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (clear_cnt_q == LAST_ADDR) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clear_cnt_q always equals the address currently presented on the RAM port
  // during CLEAR, so the last-address compare ends the clear on the final write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clear_cnt_q <= '0;
      clear_col_q <= '0;
      rr_q        <= 1'b0;
      oob_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      if (clear_accept) begin
        clear_cnt_q <= '0;
        clear_col_q <= bus.clear_color;
        we_q        <= 1'b1;
        addr_q      <= '0;
        data_q      <= bus.clear_color;
      end else if (state_q == S_CLEAR && clear_cnt_q != LAST_ADDR) begin
        clear_cnt_q <= clear_cnt_q + 1'b1;
        we_q        <= 1'b1;
        addr_q      <= clear_cnt_q + 1'b1;
        data_q      <= clear_col_q;
      end else if (gnt0) begin
        we_q   <= inr0;
        addr_q <= lin0;
        data_q <= bus.pix0;
        rr_q   <= 1'b1;
        if (!inr0) oob_q <= 1'b1;
      end else if (gnt1) begin
        we_q   <= inr1;
        addr_q <= lin1;
        data_q <= bus.pix1;
        rr_q   <= 1'b0;
        if (!inr1) oob_q <= 1'b1;
      end
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.clear_busy = busy;
  assign bus.clear_done = done;
  assign bus.oob_err    = oob_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; the frame is shortened to 640x4 so
// full clears stay short while the 640-wide address arithmetic is unchanged.
module tb_fb_write_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 9;
  localparam int H_RES  = 640;
  localparam int V_RES  = 4;
  localparam int FRAME  = H_RES * V_RES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  logic       mon_en = 1'b0;
  logic       rr_exp = 1'b0;
  logic       saw;
  int         errors = 0;
  int         checks = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_write_arbiter #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int a, input logic [DATA_W-1:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endtask

  // scoreboard: every RAM write must match the oldest expected entry
  always @(negedge clk) begin
    if (mon_en && bus.ram_we === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.ram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("write_data", 32'(bus.ram_data), 32'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic run_clear(input logic [DATA_W-1:0] color);
    cyc(); bus.clear_start = 1'b1; bus.clear_color = color;
    smp(); chk("clr_start_busy", 32'(bus.clear_busy), 32'd0);
    for (int a = 0; a < FRAME; a++) push(a, color);
    saw = 1'b0;
    cyc(); bus.clear_start = 1'b0; bus.clear_color = '0;
    smp();
    chk("clr_first_we", 32'(bus.ram_we), 32'd1);
    chk("clr_busy", 32'(bus.clear_busy), 32'd1);
    chk("clr_state", 32'(state_dbg), 32'd1);
    for (int k = 1; k < FRAME; k++) begin
      cyc(); smp();
      if (bus.clear_done !== 1'b0) saw = 1'b1;
    end
    chk("clr_no_early_done", 32'(saw), 32'd0);
    cyc(); smp();
    chk("clr_done", 32'(bus.clear_done), 32'd1);
    chk("clr_done_busy", 32'(bus.clear_busy), 32'd1);
    chk("clr_done_we", 32'(bus.ram_we), 32'd0);
    cyc(); smp();
    chk("clr_after_busy", 32'(bus.clear_busy), 32'd0);
    chk("clr_after_done", 32'(bus.clear_done), 32'd0);
  endtask

  initial begin
    bus.clear_start = 1'b0; bus.clear_color = '0;
    bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.pix0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.pix1 = '0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_busy", 32'(bus.clear_busy), 32'd0);
    chk("rst_done", 32'(bus.clear_done), 32'd0);
    chk("rst_oob", 32'(bus.oob_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    cyc(); rst_n = 1'b1; mon_en = 1'b1;

    // single request, immediate grant, one-cycle write latency
    cyc(); bus.req0 = 1'b1; bus.x0 = 10'd5; bus.y0 = 9'd2; bus.pix0 = 9'h1A5;
    smp();
    chk("t1_gnt0", 32'(bus.gnt0), 32'd1);
    chk("t1_gnt1", 32'(bus.gnt1), 32'd0);
    push(1285, 9'h1A5); rr_exp = 1'b1;
    cyc(); bus.req0 = 1'b0;
    smp();
    chk("t1_we", 32'(bus.ram_we), 32'd1);
    chk("t1_addr", 32'(bus.ram_addr), 32'd1285);
    chk("t1_oob", 32'(bus.oob_err), 32'd0);
    cyc(); smp();
    chk("t1_idle_we", 32'(bus.ram_we), 32'd0);

    // both requesters held: alternating grants, continuous writes
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.req0 = 1'b1; bus.x0 = 10'd10; bus.y0 = 9'd1; bus.pix0 = 9'h055;
      bus.req1 = 1'b1; bus.x1 = 10'd3;  bus.y1 = 9'd3; bus.pix1 = 9'h0AA;
      smp();
      chk("t2_gnt0", 32'(bus.gnt0), 32'(!rr_exp));
      chk("t2_gnt1", 32'(bus.gnt1), 32'(rr_exp));
      if (rr_exp) push(1923, 9'h0AA); else push(650, 9'h055);
      if (i > 0) chk("t2_we", 32'(bus.ram_we), 32'd1);
      rr_exp = !rr_exp;
    end
    cyc(); bus.req0 = 1'b0; bus.req1 = 1'b0;
    smp(); chk("t2_last_we", 32'(bus.ram_we), 32'd1);
    cyc(); smp(); chk("t2_idle_we", 32'(bus.ram_we), 32'd0);

    // full-frame clear
    run_clear(9'h1FF);

    // request pending across a clear, plus an ignored second clear_start
    cyc();
    bus.clear_start = 1'b1; bus.clear_color = 9'h0F0;
    bus.req1 = 1'b1; bus.x1 = 10'd7; bus.y1 = 9'd0; bus.pix1 = 9'h123;
    smp();
    chk("t4_clear_wins", 32'(bus.gnt1), 32'd0);
    for (int a = 0; a < FRAME; a++) push(a, 9'h0F0);
    saw = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      cyc(); bus.clear_start = (k == 100);
      smp();
      if (bus.gnt1 !== 1'b0) saw = 1'b1;
    end
    chk("t4_no_gnt_in_clear", 32'(saw), 32'd0);
    cyc(); bus.clear_start = 1'b0;
    smp();
    chk("t4_done", 32'(bus.clear_done), 32'd1);
    chk("t4_done_gnt1", 32'(bus.gnt1), 32'd0);
    cyc(); smp();
    chk("t4_gnt1_after", 32'(bus.gnt1), 32'd1);
    push(7, 9'h123); rr_exp = 1'b0;
    cyc(); bus.req1 = 1'b0;
    smp(); chk("t4_busy", 32'(bus.clear_busy), 32'd0);

    // out-of-range coordinates: granted, not written, sticky flag
    cyc(); bus.req0 = 1'b1; bus.x0 = 10'd640; bus.y0 = 9'd0; bus.pix0 = 9'h001;
    smp(); chk("t5_oob_gnt", 32'(bus.gnt0), 32'd1);
    cyc(); bus.req0 = 1'b0;
    smp();
    chk("t5_oob_we", 32'(bus.ram_we), 32'd0);
    chk("t5_oob_flag", 32'(bus.oob_err), 32'd1);
    cyc(); bus.req0 = 1'b1; bus.x0 = 10'd639; bus.y0 = 9'd3; bus.pix0 = 9'h1C3;
    smp(); chk("t5_valid_gnt", 32'(bus.gnt0), 32'd1);
    push(2559, 9'h1C3);
    cyc(); bus.req0 = 1'b0; bus.req1 = 1'b1; bus.x1 = 10'd0; bus.y1 = 9'd4; bus.pix1 = 9'h002;
    smp();
    chk("t5_valid_we", 32'(bus.ram_we), 32'd1);
    chk("t5_flag_held", 32'(bus.oob_err), 32'd1);
    chk("t5_yoob_gnt", 32'(bus.gnt1), 32'd1);
    cyc(); bus.req1 = 1'b0;
    smp(); chk("t5_yoob_we", 32'(bus.ram_we), 32'd0);

    // reset in the middle of a clear
    cyc(); bus.clear_start = 1'b1; bus.clear_color = 9'h0AB;
    smp();
    for (int a = 0; a <= 1000; a++) push(a, 9'h0AB);
    cyc(); bus.clear_start = 1'b0;
    repeat (1000) cyc();
    rst_n = 1'b0;
    smp(); chk("t6_addr_at_rst", 32'(bus.ram_addr), 32'd1000);
    cyc(); rst_n = 1'b1;
    smp();
    chk("t6_we", 32'(bus.ram_we), 32'd0);
    chk("t6_busy", 32'(bus.clear_busy), 32'd0);
    chk("t6_done", 32'(bus.clear_done), 32'd0);
    chk("t6_state", 32'(state_dbg), 32'd0);
    chk("t6_oob_cleared", 32'(bus.oob_err), 32'd0);
    saw = 1'b0;
    repeat (5) begin
      cyc(); smp();
      if (bus.clear_done !== 1'b0 || bus.ram_we !== 1'b0) saw = 1'b1;
    end
    chk("t6_quiet", 32'(saw), 32'd0);
    rr_exp = 1'b0;
    cyc();
    bus.req0 = 1'b1; bus.x0 = 10'd1; bus.y0 = 9'd0; bus.pix0 = 9'h011;
    bus.req1 = 1'b1; bus.x1 = 10'd2; bus.y1 = 9'd0; bus.pix1 = 9'h022;
    smp();
    chk("t6_rr_gnt0", 32'(bus.gnt0), 32'd1);
    chk("t6_rr_gnt1", 32'(bus.gnt1), 32'd0);
    push(1, 9'h011);
    cyc(); bus.req0 = 1'b0; bus.req1 = 1'b0;
    smp();
    cyc(); smp();
    run_clear(9'h055);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
